tmr_cnt_ctrl: RTL and testbench

Counter/sequencer that drives the timer status register flags. It runs an up/down counter of width CNT_W, clocked by a selectable prescaler.
- Issues single-cycle tsr_ovf_flag / tsr_udf_flag pulses on wrap-around.
- Reads back the status register's tsr_clear_flag to raise interrupts.
- Optionally stalls counting while a flag is pending.
It sits between the APB-side control/data registers and the status register, in the tsr_clk domain.

---
 rtl/tmr_cnt_ctrl.sv | 114 +++++++++++
 tb/tb_tmr_cnt_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_cnt_ctrl.sv
// rtl/tmr_cnt_ctrl.sv - prescaled up/down timer counter driving status-register flag pulses
module tmr_cnt_ctrl #(
  parameter int CNT_W        = 8,
  parameter int PSC_W        = 4,
  parameter int HALT_ON_FLAG = 0
) (
  input  logic             tsr_clk,
  input  logic             tsr_reset_n,
  input  logic             cfg_en,
  input  logic             cfg_up_dn,
  input  logic [1:0]       cfg_cks,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_load_val,
  input  logic             cfg_ovf_ie,
  input  logic             cfg_udf_ie,
  input  logic [1:0]       tsr_clear_flag,
  output logic [CNT_W-1:0] cnt,
  output logic             tsr_ovf_flag,
  output logic             tsr_udf_flag,
  output logic             irq_ovf,
  output logic             irq_udf,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_mask;
  logic [1:0]       cks_q;
  logic             cks_chg;
  logic             tick;
  logic             psc_clr;
  logic             flag_pending;
  logic             halt_req;

  assign flag_pending = |tsr_clear_flag;
  assign halt_req     = (HALT_ON_FLAG != 0) && flag_pending;
  assign cks_chg      = (cfg_cks != cks_q);
  assign psc_mask     = PSC_W'((32'd2 << cfg_cks) - 32'd1);

  // A divider change restarts the prescale period, so a stale phase must not tick.
  assign tick = (state == ST_RUN) && !cks_chg && ((psc & psc_mask) == psc_mask);

  always_ff @(posedge tsr_clk or negedge tsr_reset_n) begin
    if (!tsr_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cfg_en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!cfg_en)       state_nxt = ST_IDLE;
        else if (halt_req) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!cfg_en)            state_nxt = ST_IDLE;
        else if (!flag_pending) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == ST_RUN);
    psc_clr = cfg_load || cks_chg || (state != ST_RUN) || (state_nxt != ST_RUN);
    irq_ovf = tsr_clear_flag[0] & cfg_ovf_ie;
    irq_udf = tsr_clear_flag[1] & cfg_udf_ie;
  end

  always_ff @(posedge tsr_clk or negedge tsr_reset_n) begin
    if (!tsr_reset_n) begin
      psc   <= '0;
      cks_q <= 2'b00;
    end else begin
      cks_q <= cfg_cks;
      if (psc_clr) psc <= '0;
      else         psc <= psc + PSC_W'(1);
    end
  end

  // Load wins over a coincident tick; that tick is dropped along with any flag.
  always_ff @(posedge tsr_clk or negedge tsr_reset_n) begin
    if (!tsr_reset_n) begin
      cnt          <= '0;
      tsr_ovf_flag <= 1'b0;
      tsr_udf_flag <= 1'b0;
    end else begin
      tsr_ovf_flag <= tick && !cfg_load && !cfg_up_dn && (cnt == CNT_MAX);
      tsr_udf_flag <= tick && !cfg_load &&  cfg_up_dn && (cnt == '0);
      if (cfg_load) begin
        cnt <= cfg_load_val;
      end else if (tick) begin
        if (cfg_up_dn) cnt <= cnt - CNT_W'(1);
        else           cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tmr_cnt_ctrl.sv
// tb/tb_tmr_cnt_ctrl.sv - randomized and directed check of tmr_cnt_ctrl against a behavioural model
module tb_tmr_cnt_ctrl;
  localparam int CW = 8;

  logic          tsr_clk = 1'b0;
  logic          tsr_reset_n;
  logic          cfg_en;
  logic          cfg_up_dn;
  logic [1:0]    cfg_cks;
  logic          cfg_load;
  logic [CW-1:0] cfg_load_val;
  logic          cfg_ovf_ie;
  logic          cfg_udf_ie;
  logic [1:0]    tsr_clear_flag;

  logic [CW-1:0] d_cnt [2];
  logic          d_ovf [2];
  logic          d_udf [2];
  logic          d_irq_ovf [2];
  logic          d_irq_udf [2];
  logic          d_busy [2];

  always #5 tsr_clk = ~tsr_clk;

  tmr_cnt_ctrl #(.CNT_W(CW), .PSC_W(4), .HALT_ON_FLAG(0)) u_dut0 (
    .tsr_clk(tsr_clk), .tsr_reset_n(tsr_reset_n), .cfg_en(cfg_en), .cfg_up_dn(cfg_up_dn),
    .cfg_cks(cfg_cks), .cfg_load(cfg_load), .cfg_load_val(cfg_load_val),
    .cfg_ovf_ie(cfg_ovf_ie), .cfg_udf_ie(cfg_udf_ie), .tsr_clear_flag(tsr_clear_flag),
    .cnt(d_cnt[0]), .tsr_ovf_flag(d_ovf[0]), .tsr_udf_flag(d_udf[0]),
    .irq_ovf(d_irq_ovf[0]), .irq_udf(d_irq_udf[0]), .busy(d_busy[0])
  );

  tmr_cnt_ctrl #(.CNT_W(CW), .PSC_W(4), .HALT_ON_FLAG(1)) u_dut1 (
    .tsr_clk(tsr_clk), .tsr_reset_n(tsr_reset_n), .cfg_en(cfg_en), .cfg_up_dn(cfg_up_dn),
    .cfg_cks(cfg_cks), .cfg_load(cfg_load), .cfg_load_val(cfg_load_val),
    .cfg_ovf_ie(cfg_ovf_ie), .cfg_udf_ie(cfg_udf_ie), .tsr_clear_flag(tsr_clear_flag),
    .cnt(d_cnt[1]), .tsr_ovf_flag(d_ovf[1]), .tsr_udf_flag(d_udf[1]),
    .irq_ovf(d_irq_ovf[1]), .irq_udf(d_irq_udf[1]), .busy(d_busy[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model: mode 0 stopped, 1 counting, 2 parked on a pending flag; phase = cycles since prescaler restart.
  int            m_mode [2];
  int            m_phase [2];
  int            m_cnt [2];
  bit            m_ovf [2];
  bit            m_udf [2];
  int            m_prev_cks [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_phase[i] = 0; m_cnt[i] = 0;
      m_ovf[i] = 0; m_udf[i] = 0; m_prev_cks[i] = 0;
    end
  endtask

  task automatic model_eval();
    for (int i = 0; i < 2; i++) begin
      int  period, nmode, cks;
      bit  counting, changed, tk, pending;
      cks      = int'(cfg_cks);
      period   = 2 ** (cks + 1);
      counting = (m_mode[i] == 1);
      changed  = (cks != m_prev_cks[i]);
      tk       = counting && !changed && ((m_phase[i] % period) == period - 1);
      pending  = (tsr_clear_flag != 2'b00);
      nmode    = m_mode[i];
      if (!cfg_en)                    nmode = 0;
      else if (m_mode[i] == 0)        nmode = 1;
      else if (m_mode[i] == 1)        nmode = (i == 1 && pending) ? 2 : 1;
      else                            nmode = pending ? 2 : 1;
      m_ovf[i] = tk && !cfg_load && !cfg_up_dn && (m_cnt[i] == 255);
      m_udf[i] = tk && !cfg_load &&  cfg_up_dn && (m_cnt[i] == 0);
      if (cfg_load)       m_cnt[i] = int'(cfg_load_val);
      else if (tk)        m_cnt[i] = cfg_up_dn ? (m_cnt[i] + 255) % 256 : (m_cnt[i] + 1) % 256;
      if (cfg_load || changed || !counting || nmode != 1) m_phase[i] = 0;
      else                                                m_phase[i] = m_phase[i] + 1;
      m_mode[i]     = nmode;
      m_prev_cks[i] = cks;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_cnt%0d", tag, i),  32'(d_cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("%s_ovf%0d", tag, i),  32'(d_ovf[i]), 32'(m_ovf[i]));
      chk($sformatf("%s_udf%0d", tag, i),  32'(d_udf[i]), 32'(m_udf[i]));
      chk($sformatf("%s_busy%0d", tag, i), 32'(d_busy[i]), 32'(m_mode[i] == 1));
      chk($sformatf("%s_iovf%0d", tag, i), 32'(d_irq_ovf[i]), 32'(tsr_clear_flag[0] & cfg_ovf_ie));
      chk($sformatf("%s_iudf%0d", tag, i), 32'(d_irq_udf[i]), 32'(tsr_clear_flag[1] & cfg_udf_ie));
    end
  endtask

  task automatic step(input string tag);
    model_eval();
    @(posedge tsr_clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    tsr_reset_n = 1'b0; cfg_en = 1'b0; cfg_up_dn = 1'b0; cfg_cks = 2'b00;
    cfg_load = 1'b0; cfg_load_val = '0; cfg_ovf_ie = 1'b0; cfg_udf_ie = 1'b0;
    tsr_clear_flag = 2'b00;
    model_reset();
    repeat (2) @(posedge tsr_clk);
    #1;
    compare_all("rst");
    chk("rst_cnt", 32'(d_cnt[0]), 32'h0);
    chk("rst_busy", 32'(d_busy[1]), 32'h0);
    tsr_reset_n = 1'b1;

    // Load FD, count up /2 through the overflow.
    cfg_load = 1'b1; cfg_load_val = 8'hFD; cfg_en = 1'b1;
    step("t1");
    chk("t1_cnt_fd", 32'(d_cnt[0]), 32'hFD);
    cfg_load = 1'b0;
    repeat (2) step("t1");
    chk("t1_cnt_fe", 32'(d_cnt[0]), 32'hFE);
    repeat (2) step("t1");
    chk("t1_cnt_ff", 32'(d_cnt[0]), 32'hFF);
    step("t1");
    chk("t1_no_early_ovf", 32'(d_ovf[0]), 32'h0);
    step("t1");
    chk("t1_cnt_00", 32'(d_cnt[0]), 32'h00);
    chk("t1_ovf", 32'(d_ovf[0]), 32'h1);
    step("t1");
    chk("t1_ovf_1cyc", 32'(d_ovf[0]), 32'h0);

    // Load 01, count down /4 through the underflow.
    cfg_load = 1'b1; cfg_load_val = 8'h01; cfg_up_dn = 1'b1; cfg_cks = 2'b01;
    step("t2");
    cfg_load = 1'b0;
    repeat (4) step("t2");
    chk("t2_cnt_00", 32'(d_cnt[0]), 32'h00);
    repeat (4) step("t2");
    chk("t2_cnt_ff", 32'(d_cnt[0]), 32'hFF);
    chk("t2_udf", 32'(d_udf[0]), 32'h1);
    chk("t2_no_ovf", 32'(d_ovf[0]), 32'h0);
    step("t2");
    chk("t2_udf_1cyc", 32'(d_udf[0]), 32'h0);

    // Halt-on-flag instance parks after an overflow until the flag clears.
    cfg_load = 1'b1; cfg_load_val = 8'hFF; cfg_up_dn = 1'b0; cfg_cks = 2'b00;
    step("t3");
    cfg_load = 1'b0;
    repeat (2) step("t3");
    chk("t3_ovf", 32'(d_ovf[1]), 32'h1);
    tsr_clear_flag = 2'b01; cfg_ovf_ie = 1'b1;
    #1;
    chk("t3_irq_ovf", 32'(d_irq_ovf[1]), 32'h1);
    step("t3");
    chk("t3_hold_busy", 32'(d_busy[1]), 32'h0);
    repeat (3) step("t3");
    chk("t3_hold_cnt", 32'(d_cnt[1]), 32'h00);
    tsr_clear_flag = 2'b00;
    step("t3");
    chk("t3_resume_busy", 32'(d_busy[1]), 32'h1);
    step("t3");
    chk("t3_resume_cnt0", 32'(d_cnt[1]), 32'h00);
    step("t3");
    chk("t3_resume_cnt1", 32'(d_cnt[1]), 32'h01);

    // Load coincident with a boundary tick discards the tick.
    cfg_load = 1'b1; cfg_load_val = 8'hFF;
    step("t4");
    cfg_load = 1'b0;
    step("t4");
    cfg_load = 1'b1; cfg_load_val = 8'h10;
    step("t4");
    chk("t4_cnt_10", 32'(d_cnt[0]), 32'h10);
    chk("t4_no_ovf", 32'(d_ovf[0]), 32'h0);
    cfg_load = 1'b0;
    step("t4");
    chk("t4_psc_cleared", 32'(d_cnt[0]), 32'h10);
    step("t4");
    chk("t4_cnt_11", 32'(d_cnt[0]), 32'h11);

    // Divider change 11 -> 00 restarts the prescaler.
    cfg_load = 1'b1; cfg_load_val = 8'h20; cfg_cks = 2'b11;
    step("t5");
    cfg_load = 1'b0;
    repeat (5) step("t5");
    cfg_cks = 2'b00;
    step("t5");
    step("t5");
    chk("t5_cnt_hold", 32'(d_cnt[0]), 32'h20);
    step("t5");
    chk("t5_cnt_inc", 32'(d_cnt[0]), 32'h21);

    // Asynchronous reset mid-run.
    cfg_load = 1'b1; cfg_load_val = 8'h42;
    step("t6");
    chk("t6_cnt_42", 32'(d_cnt[0]), 32'h42);
    cfg_load = 1'b0;
    #1;
    tsr_reset_n = 1'b0;
    #1;
    model_reset();
    chk("t6_arst_cnt", 32'(d_cnt[0]), 32'h0);
    chk("t6_arst_busy", 32'(d_busy[0]), 32'h0);
    chk("t6_arst_ovf", 32'(d_ovf[0]), 32'h0);
    compare_all("t6r");
    @(posedge tsr_clk);
    #1;
    compare_all("t6r");
    tsr_reset_n = 1'b1;
    step("t6");
    chk("t6_rerun_busy", 32'(d_busy[0]), 32'h1);
    repeat (2) step("t6");
    chk("t6_restart_cnt", 32'(d_cnt[0]), 32'h01);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      cfg_en    = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) cfg_up_dn = 1'($urandom);
      if ($urandom_range(0, 24) == 0) cfg_cks   = 2'($urandom);
      cfg_load = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 4))
        0:       cfg_load_val = 8'h00;
        1:       cfg_load_val = 8'hFF;
        2:       cfg_load_val = 8'hFE;
        3:       cfg_load_val = 8'h01;
        default: cfg_load_val = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) tsr_clear_flag = 2'($urandom);
      cfg_ovf_ie = 1'($urandom);
      cfg_udf_ie = 1'($urandom);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
